op_vector_driver: RTL and testbench
===================================

// Module: op_vector_driver
// PURPOSE
//   Synthesizable stimulus and checker for multi_edge_clk (c = a+b on posedge, f = c-d on negedge).
//   Drives a/b/d operand vectors from a 24-bit LFSR and samples the DUT's c/f one posedge after they settle.
//   Compares them against expected sums and differences, then reports pass/fail, error count and first failing index.
//   Sits beside multi_edge_clk on the same clk as its on-chip self-test harness.
// PARAMETERS
//   NUM_VEC   16          vectors per run, 1..255
//   SEED      24'h0F0A05  LFSR seed {a,b,d}; SEED==0 is replaced by 24'h000001
// PORTS
//   clk       in   1   system clock; all logic on posedge
//   rst       in   1   synchronous, active-high reset
//   start     in   1   begin a run; sampled only in IDLE
//   c         in   8   DUT sum output
//   f         in   8   DUT difference output
//   a         out  8   operand A to DUT (registered)
//   b         out  8   operand B to DUT (registered)
//   d         out  8   operand D to DUT (registered)
//   busy      out  1   high from accepted start until done
//   done      out  1   one-cycle pulse after final check
//   pass      out  1   1 = last run had zero mismatches; valid from done until next start
//   err_cnt   out  8   mismatching vectors in current/last run, saturates at 255
//   fail_idx  out  8   index of first mismatching vector; 8'hFF if none
// BEHAVIOUR
//   Reset values: a=b=d=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=8'hFF.
//     State=IDLE, lfsr=SEED (or 1), vector index=0.
//   States: IDLE -> APPLY -> SETTLE -> (APPLY | FINISH) -> IDLE.
//   IDLE + start at posedge p0:
//     {a,b,d} <= lfsr, busy<=1, err_cnt<=0, fail_idx<=FF, pass<=0, state<=APPLY.
//   APPLY (1 cycle): DUT registers c=a+b at the next posedge and f=c-d at the following negedge.
//     Advance the LFSR; state<=SETTLE.
//   SETTLE (1 cycle): at its closing posedge, compare c==(a+b)[7:0] and f==(a+b-d)[7:0], both mod 256.
//     On mismatch: err_cnt++ (saturating); fail_idx<=idx if it is still FF.
//     If idx<NUM_VEC-1: idx++, {a,b,d}<=lfsr, state<=APPLY. Else state<=FINISH.
//   Vector k is applied at p0+2k and checked at p0+2k+2. The last check is at p0+2*NUM_VEC.
//   FINISH (1 cycle): done=1, busy=0, pass=(err_cnt==0 including the final check).
//     lfsr<=SEED; state<=IDLE.
//   LFSR: Fibonacci, shift left; new bit0 = s[23]^s[22]^s[21]^s[16].
//     Steps exactly once per vector, so vector 0 is always SEED.
//   a/b/d hold their last vector after the run. err_cnt, fail_idx and pass hold until the next start.
//   start while busy or in FINISH: ignored, no effect.
//   rst mid-run: immediate return to reset values. The sequence restarts from SEED on the next start.
//   Every run reproduces the identical vector sequence.
//   NUM_VEC=1: one APPLY/SETTLE pair, then done at p0+3.
// TESTING
//   1 Reset: hold rst 3 cycles -> all outputs at reset values, state IDLE, busy=0.
//   2 SEED=24'h0F0A05, NUM_VEC=4, real DUT: first vector a=15,b=10,d=5 gives c=25,f=20.
//     -> done pulses 1 cycle after p0+8; pass=1, err_cnt=0, fail_idx=FF.
//   3 SEED=24'hC86432 (a=200,b=100,d=50), NUM_VEC=1 -> c=44, f=250 wrap accepted; pass=1.
//   4 Fault model forces c[0] inverted on vector 2 only, NUM_VEC=4 -> err_cnt=1, fail_idx=2, pass=0.
//   5 start pulsed at p0+3 while busy -> ignored; run ends at the same cycle as test 2.
//     rst at p0+5 -> reset values; a new start replays vector 0 = 15/10/5.
//   6 Two back-to-back runs -> identical a/b/d sequences; err_cnt cleared at the second start.

Source files
------------

// File: rtl/op_vector_driver_if.sv
// Operand/result bundle between op_vector_driver (master) and the adder/subtractor
// under test (slave), plus the run-control and status lines.
interface op_vector_driver_if;
   logic       start;
   logic [7:0] c;
   logic [7:0] f;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] d;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_cnt;
   logic [7:0] fail_idx;

   modport master (
      input  start, c, f,
      output a, b, d, busy, done, pass, err_cnt, fail_idx
   );

   modport slave (
      output start, c, f,
      input  a, b, d, busy, done, pass, err_cnt, fail_idx
   );
endinterface

// File: rtl/op_vector_driver.sv
// On-chip self-test driver for multi_edge_clk: applies LFSR operand vectors and
// checks c = a+b and f = a+b-d (mod 256), reporting pass, error count and first failing index.
module op_vector_driver #(
   parameter int unsigned NUM_VEC = 16,
   parameter logic [23:0] SEED    = 24'h0F0A05
) (
   input  logic               clk,
   input  logic               rst,
   op_vector_driver_if.master bus
);

   localparam logic [23:0] SEED_EFF = (SEED == 24'h000000) ? 24'h000001 : SEED;
   localparam logic [7:0]  LAST_IDX = 8'(NUM_VEC - 1);

   function automatic logic [23:0] lfsr_next(input logic [23:0] s);
      return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
   endfunction

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SETTLE = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t      state_r;
   logic [23:0] lfsr_r;
   logic [7:0]  idx_r;
   logic [7:0]  a_r;
   logic [7:0]  b_r;
   logic [7:0]  d_r;
   logic        busy_r;
   logic        done_r;
   logic        pass_r;
   logic [7:0]  err_cnt_r;
   logic [7:0]  fail_idx_r;

   logic [7:0]  sum_s;
   logic [7:0]  diff_s;
   logic        mismatch_s;
   logic [7:0]  err_inc_s;

   // Expected results for the vector currently held on a/b/d, and the saturating error increment.
   always_comb begin
      sum_s      = a_r + b_r;
      diff_s     = sum_s - d_r;
      mismatch_s = (bus.c != sum_s) || (bus.f != diff_s);
      if (err_cnt_r == 8'hFF) begin
         err_inc_s = 8'hFF;
      end else begin
         err_inc_s = err_cnt_r + 8'd1;
      end
   end

   // Run sequencer: one APPLY/SETTLE pair per vector, then a single FINISH cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         lfsr_r     <= SEED_EFF;
         idx_r      <= 8'd0;
         a_r        <= 8'd0;
         b_r        <= 8'd0;
         d_r        <= 8'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
         err_cnt_r  <= 8'd0;
         fail_idx_r <= 8'hFF;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  {a_r, b_r, d_r} <= lfsr_r;
                  idx_r           <= 8'd0;
                  busy_r          <= 1'b1;
                  pass_r          <= 1'b0;
                  err_cnt_r       <= 8'd0;
                  fail_idx_r      <= 8'hFF;
                  state_r         <= APPLY;
               end
            end
            APPLY: begin
               lfsr_r  <= lfsr_next(lfsr_r);
               state_r <= SETTLE;
            end
            SETTLE: begin
               if (mismatch_s) begin
                  err_cnt_r <= err_inc_s;
                  if (fail_idx_r == 8'hFF) begin
                     fail_idx_r <= idx_r;
                  end
               end
               if (idx_r < LAST_IDX) begin
                  idx_r           <= idx_r + 8'd1;
                  {a_r, b_r, d_r} <= lfsr_r;
                  state_r         <= APPLY;
               end else begin
                  state_r <= FINISH;
               end
            end
            FINISH: begin
               // err_cnt_r already includes the final vector's result here.
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               pass_r  <= (err_cnt_r == 8'd0);
               lfsr_r  <= SEED_EFF;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.a        = a_r;
   assign bus.b        = b_r;
   assign bus.d        = d_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.pass     = pass_r;
   assign bus.err_cnt  = err_cnt_r;
   assign bus.fail_idx = fail_idx_r;

endmodule

// File: tb/tb_op_vector_driver.sv
// Scoreboard bench for op_vector_driver with a behavioural multi_edge_clk model
// (c = a+b on posedge, f = c-d on negedge) and an optional c[0] fault on vector 2.
module tb_op_vector_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   op_vector_driver_if bus0 ();
   op_vector_driver_if bus1 ();

   op_vector_driver #(.NUM_VEC(4), .SEED(24'h0F0A05)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.master)
   );

   op_vector_driver #(.NUM_VEC(1), .SEED(24'hC86432)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.master)
   );

   // Behavioural adder/subtractor models
   logic [7:0] c0_r = 8'd0;
   logic [7:0] f0_r = 8'd0;
   logic [7:0] c1_r = 8'd0;
   logic [7:0] f1_r = 8'd0;
   logic       fault_en = 1'b0;

   always @(posedge clk) c0_r <= bus0.a + bus0.b;
   always @(negedge clk) f0_r <= c0_r - bus0.d;
   always @(posedge clk) c1_r <= bus1.a + bus1.b;
   always @(negedge clk) f1_r <= c1_r - bus1.d;

   assign bus0.c = c0_r ^ {7'd0, fault_en && (bus0.a == 8'd60) && (bus0.b == 8'd40) && (bus0.d == 8'd22)};
   assign bus0.f = f0_r;
   assign bus1.c = c1_r;
   assign bus1.f = f1_r;

   typedef struct {
      logic       pass;
      logic [7:0] err_cnt;
      logic [7:0] fail_idx;
      int         lat;
      logic [7:0] c;
      logic [7:0] f;
   } res_t;

   res_t        res_q0[$];
   res_t        res_q1[$];
   logic [23:0] vec_q0[$];

   // Hand-computed LFSR sequence from seed 0F0A05: {a,b,d}
   logic [23:0] vec_tbl [4] = '{24'h0F0A05, 24'h1E140B, 24'h3C2816, 24'h78502D};

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int p0_0 = 0;
   int p0_1 = 0;
   bit vec_active0 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Vector monitor: vector k must be on a/b/d after posedge p0+2k
   always @(negedge clk) begin : vec_mon
      int j;
      logic [23:0] e;
      j = cyc - p0_0;
      if (vec_active0 && (j >= 0) && (j % 2 == 0) && (j / 2 < 4)) begin
         if (vec_q0.size() == 0) begin
            check("vec_queue_underrun", 32'd1, 32'd0);
         end else begin
            e = vec_q0.pop_front();
            check("vec_abd", {8'd0, bus0.a, bus0.b, bus0.d}, {8'd0, e});
         end
      end
   end

   // Result monitor, instance 0
   always @(negedge clk) begin : res_mon0
      res_t r;
      if (bus0.done) begin
         if (res_q0.size() == 0) begin
            check("done0_unexpected", 32'd1, 32'd0);
         end else begin
            r = res_q0.pop_front();
            check("pass0",     {31'd0, bus0.pass}, {31'd0, r.pass});
            check("err_cnt0",  {24'd0, bus0.err_cnt}, {24'd0, r.err_cnt});
            check("fail_idx0", {24'd0, bus0.fail_idx}, {24'd0, r.fail_idx});
            check("latency0",  cyc - p0_0, r.lat);
            check("busy0_low", {31'd0, bus0.busy}, 32'd0);
         end
      end
   end

   // Result monitor, instance 1 (single vector with wrap-around)
   always @(negedge clk) begin : res_mon1
      res_t r;
      if (bus1.done) begin
         if (res_q1.size() == 0) begin
            check("done1_unexpected", 32'd1, 32'd0);
         end else begin
            r = res_q1.pop_front();
            check("pass1",     {31'd0, bus1.pass}, {31'd0, r.pass});
            check("err_cnt1",  {24'd0, bus1.err_cnt}, {24'd0, r.err_cnt});
            check("fail_idx1", {24'd0, bus1.fail_idx}, {24'd0, r.fail_idx});
            check("latency1",  cyc - p0_1, r.lat);
            check("c1_wrap",   {24'd0, bus1.c}, {24'd0, r.c});
            check("f1_wrap",   {24'd0, bus1.f}, {24'd0, r.f});
         end
      end
   end

   task automatic check_reset0(input string tag);
      check({tag, "_abd"},      {8'd0, bus0.a, bus0.b, bus0.d}, 32'd0);
      check({tag, "_busy"},     {31'd0, bus0.busy}, 32'd0);
      check({tag, "_done"},     {31'd0, bus0.done}, 32'd0);
      check({tag, "_pass"},     {31'd0, bus0.pass}, 32'd0);
      check({tag, "_err_cnt"},  {24'd0, bus0.err_cnt}, 32'd0);
      check({tag, "_fail_idx"}, {24'd0, bus0.fail_idx}, 32'h0000_00FF);
   endtask

   task automatic wait_done(input bit which, input string tag);
      int n;
      n = 0;
      while (((which ? bus1.done : bus0.done) !== 1'b1) && (n < 40)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         check({tag, "_timeout"}, 32'd1, 32'd0);
      end else begin
         @(negedge clk);
         check({tag, "_done_pulse"}, {31'd0, which ? bus1.done : bus0.done}, 32'd0);
      end
   endtask

   // One run on instance 0; poke = extra start at p0+3, rst5 = reset sampled at p0+5
   task automatic run0(input bit fault, input bit poke, input bit rst5,
                       input logic [7:0] e_err, input logic [7:0] e_fidx, input logic e_pass);
      res_t r;
      fault_en = fault;
      foreach (vec_tbl[k]) vec_q0.push_back(vec_tbl[k]);
      r.pass = e_pass; r.err_cnt = e_err; r.fail_idx = e_fidx; r.lat = 9; r.c = 8'd0; r.f = 8'd0;
      res_q0.push_back(r);
      p0_0 = cyc + 1;
      vec_active0 = 1'b1;
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      check("start_busy",     {31'd0, bus0.busy}, 32'd1);
      check("start_err_clr",  {24'd0, bus0.err_cnt}, 32'd0);
      check("start_fidx_clr", {24'd0, bus0.fail_idx}, 32'h0000_00FF);
      if (poke) begin
         repeat (2) @(negedge clk);
         bus0.start = 1'b1;
         @(negedge clk);
         bus0.start = 1'b0;
      end
      if (rst5) begin
         repeat (4) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         vec_active0 = 1'b0;
         vec_q0.delete();
         res_q0.delete();
         check_reset0("midrun_rst");
         rst = 1'b0;
         @(negedge clk);
      end else begin
         wait_done(1'b0, "run0");
      end
   endtask

   initial begin
      res_t r;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset0("reset");
      check("reset1_fail_idx", {24'd0, bus1.fail_idx}, 32'h0000_00FF);
      check("reset1_busy",     {31'd0, bus1.busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Clean run, then faulty run, then clean run back-to-back
      run0(1'b0, 1'b0, 1'b0, 8'd0, 8'hFF, 1'b1);
      run0(1'b1, 1'b0, 1'b0, 8'd1, 8'd2,  1'b0);
      run0(1'b0, 1'b0, 1'b0, 8'd0, 8'hFF, 1'b1);

      // start while busy is ignored; same completion cycle
      run0(1'b0, 1'b1, 1'b0, 8'd0, 8'hFF, 1'b1);

      // Reset mid-run, then the sequence replays from the seed
      run0(1'b0, 1'b0, 1'b1, 8'd0, 8'hFF, 1'b1);
      run0(1'b0, 1'b0, 1'b0, 8'd0, 8'hFF, 1'b1);

      // a/b/d hold the last vector after the run
      check("hold_abd", {8'd0, bus0.a, bus0.b, bus0.d}, 32'h0078_502D);

      // Single-vector instance: 200+100 wraps to 44, 44-50 wraps to 250
      r.pass = 1'b1; r.err_cnt = 8'd0; r.fail_idx = 8'hFF; r.lat = 3; r.c = 8'd44; r.f = 8'd250;
      res_q1.push_back(r);
      p0_1 = cyc + 1;
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      check("inst1_abd", {8'd0, bus1.a, bus1.b, bus1.d}, 32'h00C8_6432);
      wait_done(1'b1, "run1");

      repeat (2) @(negedge clk);
      check("res_q0_drained", res_q0.size(), 32'd0);
      check("res_q1_drained", res_q1.size(), 32'd0);
      check("vec_q0_drained", vec_q0.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
